mult4_arbiter: RTL and testbench

Shares one combinational 4x4 array multiplier (Array_Mult4_gen) between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin, and the multiplier sees only registered operands. The block sits between client FSMs and the multiplier datapath and owns all sequencing of that datapath.

---
 rtl/mult4_arbiter_pkg.sv | 17 +
 rtl/mult4_arbiter_mult.sv | 22 ++
 rtl/mult4_arbiter.sv | 104 ++++++++++
 tb/tb_mult4_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult4_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM encodings
// and the operand/product width relationship.
package mult4_arbiter_pkg;

    localparam int MULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult4_arbiter_mult.sv
// Combinational 4x4 unsigned array multiplier: one AND row per multiplier bit,
// each row shifted into place and accumulated.
module Array_Mult4_gen (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] row [4];
    logic [7:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            row[i] = {4'b0000, a & {4{b[i]}}} << i;
            acc    = acc + row[i];
        end
    end

    assign p = acc;

endmodule

// File: rtl/mult4_arbiter.sv
// Round-robin arbiter that shares one 4x4 array multiplier between two
// requesters, each with valid/ready request and response channels.
module mult4_arbiter
    import mult4_arbiter_pkg::*;
#(
    parameter int WIDTH     = MULT_WIDTH,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [WIDTH-1:0]      req0_x,
    input  logic [WIDTH-1:0]      req0_y,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [2*WIDTH-1:0]    rsp0_p,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [WIDTH-1:0]      req1_x,
    input  logic [WIDTH-1:0]      req1_y,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [2*WIDTH-1:0]    rsp1_p,
    output logic                  busy
);

    localparam int PW = prod_width(WIDTH);

    // Handshake rule on all four channels: a transfer happens on a rising edge
    // where valid and ready are both 1; a request may be withdrawn while idle,
    // and a response holds valid and data stable until its ready is seen.

    state_t           state;
    logic             ptr;
    logic             owner;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    mult_p;

    logic gnt_any;
    logic gnt_id;
    logic accept;
    logic owner_rsp_ready;

    Array_Mult4_gen u_mult (
        .a (x_q),
        .b (y_q),
        .p (mult_p)
    );

    // Pointer only breaks ties; a lone requester is granted regardless.
    assign gnt_any = req0_valid | req1_valid;
    assign gnt_id  = (req0_valid && req1_valid) ? ptr : req1_valid;

    assign req0_ready = (state == ST_IDLE) && gnt_any && !gnt_id && !rst;
    assign req1_ready = (state == ST_IDLE) && gnt_any &&  gnt_id && !rst;
    assign accept     = req0_ready | req1_ready;

    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) &&  owner;
    assign rsp0_p     = rsp0_valid ? p_q : '0;
    assign rsp1_p     = rsp1_valid ? p_q : '0;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= PRIO_INIT;
            owner <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            p_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        x_q   <= gnt_id ? req1_x : req0_x;
                        y_q   <= gnt_id ? req1_y : req0_y;
                        owner <= gnt_id;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    p_q   <= mult_p;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // Priority moves to the other requester only once the
                    // product has actually been consumed.
                    if (owner_rsp_ready) begin
                        ptr   <= ~owner;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult4_arbiter.sv
// Bench for mult4_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_mult4_arbiter;

    localparam bit PRIO_INIT = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 0, req1_valid = 0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1, rsp1_ready = 1;
    logic [7:0] rsp0_p, rsp1_p;
    logic       busy;

    mult4_arbiter #(.WIDTH(4), .PRIO_INIT(PRIO_INIT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level model: one product in flight, visible from its second cycle.
    bit         m_seen  = 0;
    bit         m_busy  = 0;
    bit         m_owner = 0;
    bit         m_ptr   = PRIO_INIT;
    int         m_age   = 0;
    logic [7:0] m_prod  = 0;

    logic [7:0] exp_q[$];
    int         acc_cyc_q[$];
    bit         acc_own_q[$];
    bit         rsp_own_q[$];
    logic [7:0] rsp_p_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : model_cmp
        bit g_any, g_id, e_r0, e_r1, e_v0, e_v1;
        logic [7:0] got;
        cyc++;
        g_any = !m_busy && (req0_valid || req1_valid);
        g_id  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        e_r0  = g_any && !g_id && !rst;
        e_r1  = g_any &&  g_id && !rst;
        e_v0  = m_busy && (m_age >= 1) && !m_owner;
        e_v1  = m_busy && (m_age >= 1) &&  m_owner;
        if (m_seen) begin
            chk("req0_ready", 8'(req0_ready), 8'(e_r0));
            chk("req1_ready", 8'(req1_ready), 8'(e_r1));
            chk("busy",       8'(busy),       8'(m_busy));
            chk("rsp0_valid", 8'(rsp0_valid), 8'(e_v0));
            chk("rsp1_valid", 8'(rsp1_valid), 8'(e_v1));
            chk("rsp0_p",     rsp0_p,         e_v0 ? m_prod : 8'h00);
            chk("rsp1_p",     rsp1_p,         e_v1 ? m_prod : 8'h00);
        end
        if (rst) begin
            m_seen = 1;
            m_busy = 0;
            m_ptr  = PRIO_INIT;
            m_age  = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (e_r0 || e_r1) begin
                m_busy  = 1;
                m_owner = g_id;
                m_age   = 0;
                m_prod  = g_id ? ({4'b0, req1_x} * {4'b0, req1_y})
                               : ({4'b0, req0_x} * {4'b0, req0_y});
                exp_q.push_back(m_prod);
                acc_cyc_q.push_back(cyc);
                acc_own_q.push_back(g_id);
            end
        end else if (m_age >= 1 && (m_owner ? rsp1_ready : rsp0_ready)) begin
            got = m_owner ? rsp1_p : rsp0_p;
            if (exp_q.size() > 0) chk("scoreboard_p", got, exp_q.pop_front());
            rsp_own_q.push_back(m_owner);
            rsp_p_q.push_back(got);
            m_busy = 0;
            m_ptr  = !m_owner;
        end else if (m_age < 2) begin
            m_age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic clear_logs();
        acc_cyc_q.delete();
        acc_own_q.delete();
        rsp_own_q.delete();
        rsp_p_q.delete();
    endtask

    // Waits for requester n's request handshake, then withdraws its valid.
    task automatic wait_accept(input bit n);
        bit ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (n ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) ok = 1;
        end
        if (ok) begin
            tick();
            if (n) req1_valid = 0; else req0_valid = 0;
        end
        chk(n ? "accept1_seen" : "accept0_seen", 8'(ok), 8'd1);
    endtask

    task automatic wait_rsp(input bit n);
        bit ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (n ? rsp1_valid : rsp0_valid) ok = 1;
        end
        chk(n ? "rsp1_seen" : "rsp0_seen", 8'(ok), 8'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (!busy && !req0_valid && !req1_valid) ok = 1;
        end
        chk("idle_reached", 8'(ok), 8'd1);
        tick();
    endtask

    initial begin
        // Test 1: single request, latency and busy window.
        do_reset();
        req0_x = 4'hF; req0_y = 4'h2; req0_valid = 1;
        @(negedge clk);
        chk("t1_req0_ready", 8'(req0_ready), 8'd1);
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("t1_calc_busy",  8'(busy),       8'd1);
        chk("t1_calc_valid", 8'(rsp0_valid), 8'd0);
        @(negedge clk);
        chk("t1_rsp_valid",  8'(rsp0_valid), 8'd1);
        chk("t1_rsp_p",      rsp0_p,         8'h1E);
        chk("t1_rsp_busy",   8'(busy),       8'd1);
        @(negedge clk);
        chk("t1_done_busy",  8'(busy),       8'd0);
        tick();

        // Test 2: simultaneous requests after reset, requester 0 first.
        do_reset();
        clear_logs();
        req0_x = 4'h3; req0_y = 4'h5; req0_valid = 1;
        req1_x = 4'hF; req1_y = 4'hF; req1_valid = 1;
        wait_accept(0);
        wait_accept(1);
        wait_idle();
        chk("t2_count", 8'(rsp_own_q.size()), 8'd2);
        if (rsp_own_q.size() == 2) begin
            chk("t2_own0", 8'(rsp_own_q[0]), 8'd0);
            chk("t2_p0",   rsp_p_q[0],       8'h0F);
            chk("t2_own1", 8'(rsp_own_q[1]), 8'd1);
            chk("t2_p1",   rsp_p_q[1],       8'hE1);
        end

        // Test 3: response backpressure holds product and blocks grants.
        clear_logs();
        rsp0_ready = 0;
        req0_x = 4'hF; req0_y = 4'h2; req0_valid = 1;
        wait_accept(0);
        req1_x = 4'h1; req1_y = 4'h1; req1_valid = 1;
        wait_rsp(0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 8'(rsp0_valid), 8'd1);
            chk("t3_hold_p",     rsp0_p,         8'h1E);
            chk("t3_hold_r0",    8'(req0_ready), 8'd0);
            chk("t3_hold_r1",    8'(req1_ready), 8'd0);
            @(negedge clk);
        end
        tick();
        rsp0_ready = 1;
        wait_accept(1);
        wait_idle();
        chk("t3_first_p", rsp_p_q.size() > 0 ? rsp_p_q[0] : 8'hXX, 8'h1E);

        // Test 4: fairness under continuous contention.
        do_reset();
        clear_logs();
        req0_x = 4'h2; req0_y = 4'h3; req1_x = 4'h4; req1_y = 4'h5;
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 40 && acc_own_q.size() < 4; k++) tick();
        req0_valid = 0; req1_valid = 0;
        wait_idle();
        chk("t4_count", 8'(acc_own_q.size()), 8'd4);
        if (acc_own_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t4_owner", 8'(acc_own_q[i]), 8'(i % 2));
            for (int i = 0; i < 3; i++)
                chk("t4_interval", 8'(acc_cyc_q[i+1] - acc_cyc_q[i]), 8'd3);
        end

        // Test 5: reset in CALC aborts; priority returns to its reset value.
        req1_x = 4'h5; req1_y = 4'h5; req1_valid = 1;
        wait_accept(1);
        rst = 1;
        tick();
        rst = 0;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_rsp0", 8'(rsp0_valid), 8'd0);
            chk("t5_no_rsp1", 8'(rsp1_valid), 8'd0);
            chk("t5_busy",    8'(busy),       8'd0);
        end
        tick();
        req0_x = 4'h7; req0_y = 4'h6; req1_x = 4'h9; req1_y = 4'h2;
        req0_valid = 1; req1_valid = 1;
        wait_accept(0);
        wait_accept(1);
        wait_idle();
        chk("t5_first_owner", acc_own_q.size() > 0 ? 8'(acc_own_q[0]) : 8'hXX, 8'd0);

        // Test 6: zero operand on requester 1.
        rsp1_ready = 0;
        req1_x = 4'h0; req1_y = 4'h9; req1_valid = 1;
        wait_accept(1);
        wait_rsp(1);
        chk("t6_rsp1_p",     rsp1_p,         8'h00);
        chk("t6_rsp1_valid", 8'(rsp1_valid), 8'd1);
        chk("t6_rsp0_valid", 8'(rsp0_valid), 8'd0);
        chk("t6_rsp0_p",     rsp0_p,         8'h00);
        tick();
        rsp1_ready = 1;
        wait_idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            tick();
            rst        = ($urandom_range(0, 99) == 0);
            req0_valid = $urandom_range(0, 2) != 0;
            req1_valid = $urandom_range(0, 2) != 0;
            req0_x     = 4'($urandom_range(0, 15));
            req0_y     = 4'($urandom_range(0, 15));
            req1_x     = 4'($urandom_range(0, 15));
            req1_y     = 4'($urandom_range(0, 15));
            rsp0_ready = $urandom_range(0, 3) != 0;
            rsp1_ready = $urandom_range(0, 3) != 0;
        end
        tick();
        rst = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
